// File: rtl/sel_lock_pkg.sv
// Shared definitions for the keyed select scrambler and descrambler.
// Both ends import this package so the key layout stays identical:
//   LANES  - number of lanes (2**SEL_W)
//   SEL_W  - width of one select code / key entry
//   KEY_W  - packed key width, entry k at key[k*SEL_W +: SEL_W]
// Also provides the key entry type, an entry extraction helper and the
// receive-side state enum.
package sel_lock_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int KEY_W = LANES * SEL_W;

  typedef logic [SEL_W-1:0] key_entry_t;

  typedef enum logic [1:0] {
    NOKEY   = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Entry k is the destination lane of the k-th bit of a serial word.
  function automatic key_entry_t key_entry(input logic [KEY_W-1:0] key,
                                           input logic [SEL_W-1:0] k);
    return key[k*SEL_W +: SEL_W];
  endfunction

endpackage

// File: rtl/sel_key_checker.sv
// Combinational key validity check.
// A key is a valid permutation when all LANES entries are pairwise distinct.
// Ports:
//   key          in  KEY_W  packed key under test
//   all_distinct out 1      1 when no two entries are equal
module sel_key_checker
  import sel_lock_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic             all_distinct
);

  always_comb begin
    all_distinct = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (key_entry(key, SEL_W'(i)) == key_entry(key, SEL_W'(j))) begin
          all_distinct = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sel_descrambler_deser.sv
// Receive-side descrambler/deserialiser for the keyed 8:1 select mux.
// Each accepted serial bit k of a word is written to lane key[k]; after
// LANES accepted bits the assembled word is presented on a valid/ready
// output one cycle later.
//
// state   | meaning
// --------+---------------------------------------------
// NOKEY   | no valid key loaded, input is refused
// COLLECT | accepting serial bits of the current word
// HOLD    | completed word waiting for the consumer
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   key_load   in   1      strobe capturing key_in (wins over data events)
//   key_in     in   KEY_W  permutation key
//   key_ok     out  1      loaded key is a valid permutation
//   key_err    out  1      last loaded key had a duplicate entry
//   in_valid   in   1      serial bit present
//   in_bit     in   1      serial data bit
//   in_ready   out  1      in_bit accepted this cycle
//   out_valid  out  1      assembled word available
//   out_data   out  LANES  assembled word, lane-ordered
//   out_ready  in   1      downstream accepts out_data
module sel_descrambler_deser
  import sel_lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_ok,
  output logic             key_err,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [LANES-1:0] out_data,
  input  logic             out_ready
);

  state_t           state, state_nxt;
  logic [KEY_W-1:0] key_q;
  logic [SEL_W-1:0] cnt, cnt_nxt;
  logic [LANES-1:0] word, word_nxt;
  logic [LANES-1:0] out_data_nxt;
  logic             out_valid_nxt;
  logic             key_ok_nxt, key_err_nxt;
  logic             key_valid;
  logic             accept;
  logic             last_bit;
  key_entry_t       lane;

  sel_key_checker u_key_checker (
    .key          (key_in),
    .all_distinct (key_valid)
  );

  // The next word's first bit may enter in the same cycle the held word
  // leaves, which keeps throughput at one word per LANES cycles.
  assign in_ready = key_ok & (~out_valid | out_ready) & ~key_load;
  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt == SEL_W'(LANES - 1));
  assign lane     = key_entry(key_q, cnt);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    word_nxt      = word;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    key_ok_nxt    = key_ok;
    key_err_nxt   = key_err;

    if (key_load) begin
      // New key discards any partial or held word.
      key_ok_nxt    = key_valid;
      key_err_nxt   = ~key_valid;
      cnt_nxt       = '0;
      word_nxt      = '0;
      out_valid_nxt = 1'b0;
      state_nxt     = key_valid ? COLLECT : NOKEY;
    end else begin
      if (out_valid && out_ready) begin
        out_valid_nxt = 1'b0;
        if (state == HOLD) begin
          state_nxt = COLLECT;
        end
      end
      if (accept) begin
        // Start every word from zero so no lane carries stale data.
        if (cnt == '0) begin
          word_nxt = '0;
        end
        word_nxt[lane] = in_bit;
        if (last_bit) begin
          cnt_nxt       = '0;
          out_data_nxt  = word_nxt;
          out_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NOKEY;
      key_q     <= '0;
      key_ok    <= 1'b0;
      key_err   <= 1'b0;
      cnt       <= '0;
      word      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      key_ok    <= key_ok_nxt;
      key_err   <= key_err_nxt;
      cnt       <= cnt_nxt;
      word      <= word_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      if (key_load) begin
        key_q <= key_in;
      end
    end
  end

endmodule
